instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/simple_arch_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 60 ++++++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/simple_arch_pkg.sv
// Purpose: shared word width, fetch FSM states, buffer entry type and buffer depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Config macro: FETCH_BUF2_EN -- when defined the fetch buffer holds two entries, else one.
package simple_arch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

`ifdef FETCH_BUF2_EN
  // Two entries let fetch run one word ahead of a stalled decoder.
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Purpose: DEPTH-entry FIFO of {instruction word, pc} between fetch and decode.
// Latency: one cycle from push to visible at head; head is a registered array read.
// Backpressure: caller must not push when full unless popping in the same cycle.
// Ports: clk, rst_n; push/push_entry write; pop advances head; flush empties;
//        head is the oldest entry; count is the number of valid entries.
module fetch_buffer
  import simple_arch_pkg::*;
#(
  parameter int DEPTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // When full, wr_ptr == rd_ptr, so push+pop overwrites the slot being retired.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Purpose: PC sequencer with redirect/halt, feeding a small instruction buffer to decode.
// Latency: word at mem_addr appears on ir_data one cycle later (buffer empty case).
// Backpressure: ir_ready=0 fills the buffer, then the PC holds until a pop frees a slot.
// Ports: clk, rst_n; mem_addr/mem_data to memory; redirect_valid/redirect_pc, halt control;
//        ir_valid/ir_ready/ir_data/ir_pc to decode.
// Config macro: FETCH_BUF2_EN selects a two-entry buffer (default one entry).
module instruction_fetch
  import simple_arch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] PC_STEP  = 16'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [WORD_W-1:0] ir_data,
  output logic [WORD_W-1:0] ir_pc
);

  localparam int DEPTH = FETCH_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_n;
  logic [WORD_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              full;
  logic              pop;
  logic              push;

  assign ir_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));

  // A redirect discards the head, so it must not also count as consumed.
  assign pop  = ir_valid & ir_ready & ~redirect_valid;
  // Halt blocks the push in the cycle it is raised, so the PC freezes immediately.
  assign push = (state == FETCH) & ~halt & ~redirect_valid & (~full | pop);

  assign push_entry.data = mem_data;
  assign push_entry.pc   = pc;

  always_comb begin
    state_n = state;
    if (redirect_valid) begin
      state_n = halt ? HALTED : FETCH;
    end else if (halt) begin
      state_n = HALTED;
    end else if (state == IDLE) begin
      state_n = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      if (redirect_valid) pc <= redirect_pc;
      else if (push)      pc <= pc + PC_STEP;
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign mem_addr = pc;
  assign ir_data  = head.data;
  assign ir_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: self-checking bench for instruction_fetch against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: ir_ready driven directed and randomly.
module tb_instruction_fetch;

`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;

  always #5 clk = ~clk;

  // Memory contents: mem[n] = n + 100.
  assign mem_data = mem_addr + 16'd100;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] p;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc;
  int          m_mode;  // 0: first clock after reset, 1: fetching, 2: halted

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 16'h0000;
    m_mode = 0;
  endtask

  // Drive one cycle of inputs, compare outputs with the model, advance model and clock.
  task automatic step(input logic rv, input logic [15:0] rp, input logic h, input logic rdy);
    logic do_pop;
    logic do_push;
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt           = h;
    ir_ready       = rdy;
    #1;
    chk("ir_valid", {15'd0, ir_valid}, {15'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("ir_data", ir_data, q[0].d);
      chk("ir_pc", ir_pc, q[0].p);
    end
    chk("mem_addr", mem_addr, m_pc);
    do_pop  = (q.size() != 0) && rdy && !rv;
    do_push = (m_mode == 1) && !h && !rv && ((q.size() < DEPTH) || do_pop);
    if (rv) begin
      q.delete();
      m_pc   = rp;
      m_mode = h ? 2 : 1;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.d = m_pc + 16'd100;
        e.p = m_pc;
        q.push_back(e);
        m_pc = m_pc + 16'd1;
      end
      if (h) m_mode = 2;
      else if (m_mode == 0) m_mode = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] head_pc;
    logic [15:0] frozen;

    // Reset state
    #3;
    chk("rst_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_data", ir_data, 16'h0000);
    chk("rst_pc", ir_pc, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_hold", mem_addr, 16'h0000);

    // Reset release, streaming with decode always ready
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s30_pc0", ir_pc, 16'd0);
    chk("s30_d0", ir_data, 16'd100);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s30_pc1", ir_pc, 16'd1);
    chk("s30_d1", ir_data, 16'd101);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s30_pc2", ir_pc, 16'd2);
    chk("s30_d2", ir_data, 16'd102);

    // Decoder stall for 5 cycles
    head_pc = ir_pc;
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("s31_addr", mem_addr, head_pc + 16'(DEPTH));
    chk("s31_pc", ir_pc, head_pc);
    chk("s31_data", ir_data, head_pc + 16'd100);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s31_next", ir_pc, head_pc + 16'd1);
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1);

    // Redirect while the buffer is full
    step(1'b1, 16'h0100, 1'b0, 1'b0);
    repeat (DEPTH + 2) step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0271, 1'b0, 1'b0);
    chk("s32_flush", {15'd0, ir_valid}, 16'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s32_pc", ir_pc, 16'h0271);
    chk("s32_data", ir_data, 16'h0271 + 16'd100);

    // PC wrap
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s33_ffff", ir_pc, 16'hFFFF);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s33_0000", ir_pc, 16'h0000);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s33_0001", ir_pc, 16'h0001);

    // Halt with one entry buffered, then resume by redirect
    step(1'b1, 16'h0200, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    frozen = mem_addr;
    chk("s34_head", ir_pc, 16'h0200);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s34_empty", {15'd0, ir_valid}, 16'd0);
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s34_frozen", mem_addr, frozen);
    step(1'b1, 16'h0036, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s34_resume", ir_pc, 16'h0036);

    // Halt and redirect together
    step(1'b1, 16'h0025, 1'b1, 1'b1);
    chk("s35_addr", mem_addr, 16'h0025);
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("s35_nopush", {15'd0, ir_valid}, 16'd0);
    chk("s35_addr_hold", mem_addr, 16'h0025);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(15) == 0), 16'($urandom), ($urandom_range(19) == 0),
           1'($urandom_range(1)));
    end

    // Asynchronous reset with entries buffered
    step(1'b1, 16'h0010, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("s25_pre", {15'd0, ir_valid}, 16'd1);
    rst_n = 1'b0;
    #2;
    chk("s25_valid", {15'd0, ir_valid}, 16'd0);
    chk("s25_addr", mem_addr, 16'h0000);
    chk("s25_pc", ir_pc, 16'h0000);
    chk("s25_data", ir_data, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
